shift_pipe: RTL
===============

Name: shift_pipe

Overview:
- Parametrised, pipelined shift/rotate unit; next generation of the 16-bit combinational shifter.
- Adds configurable width, rotate ops, carry/zero flags, sideband tag, and a valid/ready handshake with back-pressure.
- Sits between the register-read stage and ALU writeback mux; accepts one op per cycle.

Parameters:
- WIDTH, 16, data width; power of two, 4..64.
- STAGES, 1, pipeline depth (1 or 2); latency in cycles from accept to out_valid.
- TAG_W, 4, width of opaque sideband tag carried alongside each op.
- AMT_W, $clog2(WIDTH)+1, shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  op present.
- in_ready  out  1  unit can accept this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  AMT_W  shift amount, unsigned.
- in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  result.
- out_carry  out  1  last bit shifted/rotated out.
- out_zero  out  1  out_data == 0.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valid bits 0; out_data, out_tag, out_carry, out_zero all 0; in_ready 1.
- Transfer occurs on a cycle with valid && ready at either side.
- stall = out_valid && !out_ready. in_ready = !stall. While stalled, every stage holds; no data changes at outputs.
- Bubbles are not compressed. Latency is exactly STAGES cycles when unstalled.
- Throughput is 1 op/cycle.
- STAGES=1: full barrel evaluated in one cycle, result registered.
- STAGES=2: the lower half of the barrel levels is evaluated in stage 1 and the upper half in stage 2. Op, amt, carry-in and tag are pipelined with the data.
- SLL/SRL: amt >= WIDTH gives 0. carry = in_data[WIDTH-amt] for SLL or in_data[amt-1] for SRL when 1 <= amt <= WIDTH, else 0.
- SRA: amt >= WIDTH gives all bits = in_data[MSB]. carry = in_data[amt-1] for amt < WIDTH, else in_data[MSB]. amt 0 gives carry 0.
- ROL/ROR: effective amount is amt mod WIDTH (low bits). carry = out_data[0] for ROL, out_data[MSB] for ROR. Effective amount 0 gives carry 0.
- amt = 0 on any op: out_data = in_data, carry 0.
- Reserved op: out_data = in_data, carry 0. Never X.
- out_zero is computed from the final out_data in the same register stage.
- Reset mid-operation: in-flight ops are discarded, outputs go to reset values, and no result is emitted after release.
- Simultaneous out accept and in accept: the pipeline advances; new op enters while the old result leaves. No bubble is inserted.

Optional Feature:
- Macro: SHIFT_PIPE_ROTATE_EN.
- Defined: ROL/ROR behave as above.
- Undefined: rotate hardware is not built. Ops 011/100 are treated as reserved (pass-through, carry 0). Area is reduced, all other behaviour is unchanged.

Decomposition:
- Shared package shift_pkg holds:
  - op encoding constants (OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR);
  - shift_op_t typedef (3 bits);
  - function amt_width(width).
- One natural sub-module, shift_pipe_level: one combinational barrel level. Inputs are data, op, amt bit and level index; outputs are shifted data and running carry. It is instantiated log2(WIDTH) times and split across stages by STAGES.

Test Plan (WIDTH=16, TAG_W=4):
- Basic ops, STAGES=1, out_ready=1, data 0x8421 amt 4:
  - SLL → 0x4210, carry 0
  - SRL → 0x0842, carry 0
  - SRA → 0xF842, carry 0
  - ROL → 0x4218
  - ROR → 0x1842
  - each result arrives exactly 1 cycle after accept
- Boundary amounts, data 0x8001:
  - SLL amt 16 → 0x0000, carry 1, zero 1
  - SRA amt 20 → 0xFFFF, carry 1
  - ROL amt 16 → 0x8001, carry 0
  - any op amt 0 → 0x8001, carry 0
- Back-pressure, STAGES=2: stream tags 0..7 with out_ready low for cycles 3-6. Required:
  - in_ready low exactly while stalled;
  - outputs stable during the stall;
  - all 8 results in order, none lost or duplicated.
- Reset mid-flight: assert rst_n low while 2 ops are in flight (STAGES=2). Required:
  - out_valid 0 immediately (asynchronous);
  - no result emitted after release;
  - the next op has latency 2.
- Reserved op 111 on 0x1234 amt 3 → 0x1234, carry 0.
- Build without SHIFT_PIPE_ROTATE_EN: ROL on 0x1234 amt 3 → 0x1234, carry 0.

Source files
------------

// File: rtl/shift_pkg.sv
// +----------------------------------------------------------------------------+
// | shift_pkg : op encodings and width helper shared by the shift_pipe slice.  |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package shift_pkg;

    typedef logic [2:0] shift_op_t;

    localparam shift_op_t OP_SLL = 3'b000;
    localparam shift_op_t OP_SRL = 3'b001;
    localparam shift_op_t OP_SRA = 3'b010;
    localparam shift_op_t OP_ROL = 3'b011;
    localparam shift_op_t OP_ROR = 3'b100;

    // One extra bit lets the amount express "WIDTH or more".
    function automatic int amt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_pipe_level.sv
// +----------------------------------------------------------------------------+
// | shift_pipe_level : one combinational barrel level, shift by 2**LEVEL.      |
// | Build option     : SHIFT_PIPE_ROTATE_EN adds the ROL/ROR datapath.         |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift_pipe_level
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEVEL = 0
) (
    input  logic [WIDTH-1:0] data_in,
    input  shift_op_t        op,
    input  logic             amt_bit,
    input  logic             carry_in,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out
);

    localparam int c_shamt = 1 << LEVEL;

    // The carry is overwritten only by an active level, so after the chain it
    // holds the bit pushed out by the highest active level, i.e. the last one.
    always_comb begin
        data_out  = data_in;
        carry_out = carry_in;
        if (amt_bit) begin
            case (op)
                OP_SLL: begin
                    data_out  = data_in << c_shamt;
                    carry_out = data_in[WIDTH-c_shamt];
                end
                OP_SRL: begin
                    data_out  = data_in >> c_shamt;
                    carry_out = data_in[c_shamt-1];
                end
                OP_SRA: begin
                    data_out  = $signed(data_in) >>> c_shamt;
                    carry_out = data_in[c_shamt-1];
                end
`ifdef SHIFT_PIPE_ROTATE_EN
                OP_ROL: begin
                    data_out  = {data_in[WIDTH-c_shamt-1:0], data_in[WIDTH-1:WIDTH-c_shamt]};
                    carry_out = data_in[WIDTH-c_shamt];
                end
                OP_ROR: begin
                    data_out  = {data_in[c_shamt-1:0], data_in[WIDTH-1:c_shamt]};
                    carry_out = data_in[c_shamt-1];
                end
`endif
                default: begin
                    data_out  = data_in;
                    carry_out = carry_in;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_pipe.sv
// +----------------------------------------------------------------------------+
// | shift_pipe : pipelined shift/rotate unit with carry/zero flags, sideband   |
// |              tag and valid/ready back-pressure (1 or 2 register stages).   |
// | Build option: SHIFT_PIPE_ROTATE_EN enables ROL/ROR (else reserved).        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4,
    parameter int AMT_W  = amt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  shift_op_t        in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int c_levels = $clog2(WIDTH);
    localparam int c_split  = (STAGES == 2) ? (c_levels / 2) : 0;

    logic             w_stall;
    logic             w_adv;

    logic [WIDTH-1:0] w_lo_data  [0:c_split];
    logic             w_lo_carry [0:c_split];

    logic             w_mid_valid;
    logic [WIDTH-1:0] w_mid_data;
    logic             w_mid_carry;
    shift_op_t        w_mid_op;
    logic [AMT_W-1:0] w_mid_amt;
    logic [TAG_W-1:0] w_mid_tag;

    logic [WIDTH-1:0] w_hi_data  [c_split:c_levels];
    logic             w_hi_carry [c_split:c_levels];

    logic [WIDTH-1:0] w_fin_data;
    logic             w_fin_carry;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_carry;
    logic             r_out_zero;
    logic [TAG_W-1:0] r_out_tag;

    assign w_stall  = r_out_valid && !out_ready;
    assign w_adv    = !w_stall;
    assign in_ready = w_adv;

    // Lower barrel levels, fed straight from the input port.
    assign w_lo_data[0]  = in_data;
    assign w_lo_carry[0] = 1'b0;

    for (genvar k = 0; k < c_split; k++) begin : g_lo
        shift_pipe_level #(.WIDTH(WIDTH), .LEVEL(k)) u_lvl (
            .data_in   (w_lo_data[k]),
            .op        (in_op),
            .amt_bit   (in_amt[k]),
            .carry_in  (w_lo_carry[k]),
            .data_out  (w_lo_data[k+1]),
            .carry_out (w_lo_carry[k+1])
        );
    end

    if (STAGES == 2) begin : g_two
        logic             r_s1_valid;
        logic [WIDTH-1:0] r_s1_data;
        logic             r_s1_carry;
        shift_op_t        r_s1_op;
        logic [AMT_W-1:0] r_s1_amt;
        logic [TAG_W-1:0] r_s1_tag;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1_valid <= 1'b0;
                r_s1_data  <= '0;
                r_s1_carry <= 1'b0;
                r_s1_op    <= OP_SLL;
                r_s1_amt   <= '0;
                r_s1_tag   <= '0;
            end else if (w_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_data  <= w_lo_data[c_split];
                    r_s1_carry <= w_lo_carry[c_split];
                    r_s1_op    <= in_op;
                    r_s1_amt   <= in_amt;
                    r_s1_tag   <= in_tag;
                end
            end
        end

        assign w_mid_valid = r_s1_valid;
        assign w_mid_data  = r_s1_data;
        assign w_mid_carry = r_s1_carry;
        assign w_mid_op    = r_s1_op;
        assign w_mid_amt   = r_s1_amt;
        assign w_mid_tag   = r_s1_tag;
    end else begin : g_one
        assign w_mid_valid = in_valid;
        assign w_mid_data  = w_lo_data[c_split];
        assign w_mid_carry = w_lo_carry[c_split];
        assign w_mid_op    = in_op;
        assign w_mid_amt   = in_amt;
        assign w_mid_tag   = in_tag;
    end

    // Upper barrel levels, fed from the stage-1 register (or the input).
    assign w_hi_data[c_split]  = w_mid_data;
    assign w_hi_carry[c_split] = w_mid_carry;

    for (genvar k = c_split; k < c_levels; k++) begin : g_hi
        shift_pipe_level #(.WIDTH(WIDTH), .LEVEL(k)) u_lvl (
            .data_in   (w_hi_data[k]),
            .op        (w_mid_op),
            .amt_bit   (w_mid_amt[k]),
            .carry_in  (w_hi_carry[k]),
            .data_out  (w_hi_data[k+1]),
            .carry_out (w_hi_carry[k+1])
        );
    end

    // Amount >= WIDTH: shifts saturate; the only nonzero shift carry left is
    // for amt == WIDTH exactly, where the data is still the untouched input.
    // Rotates ignore this bit (amount taken modulo WIDTH).
    always_comb begin
        w_fin_data  = w_hi_data[c_levels];
        w_fin_carry = w_hi_carry[c_levels];
        if (w_mid_amt[c_levels]) begin
            case (w_mid_op)
                OP_SLL: begin
                    w_fin_data  = '0;
                    w_fin_carry = (w_mid_amt[c_levels-1:0] == '0) ? w_hi_data[c_levels][0] : 1'b0;
                end
                OP_SRL: begin
                    w_fin_data  = '0;
                    w_fin_carry = (w_mid_amt[c_levels-1:0] == '0) ? w_hi_data[c_levels][WIDTH-1] : 1'b0;
                end
                OP_SRA: begin
                    w_fin_data  = {WIDTH{w_hi_data[c_levels][WIDTH-1]}};
                    w_fin_carry = w_hi_data[c_levels][WIDTH-1];
                end
                default: begin
                    w_fin_data  = w_hi_data[c_levels];
                    w_fin_carry = w_hi_carry[c_levels];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_carry <= 1'b0;
            r_out_zero  <= 1'b0;
            r_out_tag   <= '0;
        end else if (w_adv) begin
            r_out_valid <= w_mid_valid;
            if (w_mid_valid) begin
                r_out_data  <= w_fin_data;
                r_out_carry <= w_fin_carry;
                r_out_zero  <= (w_fin_data == '0);
                r_out_tag   <= w_mid_tag;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_carry = r_out_carry;
    assign out_zero  = r_out_zero;
    assign out_tag   = r_out_tag;

endmodule

`default_nettype wire
